tsc_serial_rx: RTL and testbench

// - Host-side receiver for the trigger surround cache readout link: requests a buffer dump (sbf),

---
 rtl/tsc_serial_rx.sv | 191 +++++++++++++++++++
 tb/tb_tsc_serial_rx.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tsc_serial_rx.sv
// Host-side receiver for the trigger surround cache readout link: requests a dump, deserialises
// NSAMP samples into a readable buffer, latches trigger time. Optional macro: TSC_RX_PARITY_EN.
module tsc_serial_rx #(
    parameter int NSAMP   = 32,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rd_req,
    output logic                     sbf,
    input  logic                     sd,
    input  logic                     cd,
    input  logic                     trd,
    input  logic [31:0]              trigtm,
    input  logic [$clog2(NSAMP)-1:0] rd_addr,
    output logic [DW-1:0]            rd_data,
    output logic [31:0]              trig_time,
    output logic                     busy,
    output logic                     done,
    output logic                     err_timeout,
`ifdef TSC_RX_PARITY_EN
    output logic                     err_parity,
`endif
    output logic [15:0]              frame_cnt
);

    localparam int AW = $clog2(NSAMP);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = $clog2(DW + 1);
`ifdef TSC_RX_PARITY_EN
    localparam int LAST_BIT = DW;
`else
    localparam int LAST_BIT = DW - 1;
`endif

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_REQ        = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_SHIFT      = 3'd3;
    localparam logic [2:0] S_WAIT_CD    = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;
    localparam logic [2:0] S_ERR        = 3'd6;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic [AW-1:0] samp_q, samp_d;
    logic [DW-1:0] sh_q, sh_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_parity_q, err_parity_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;
    logic          trd_q;
    logic [31:0]   trig_time_q, trig_time_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [DW-1:0] mem_q [NSAMP];
    logic          wr_en;
    logic [DW-1:0] wr_data;

    assign wr_data = {sh_q[DW-2:0], sd};

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        samp_d        = samp_q;
        sh_d          = sh_q;
        err_timeout_d = err_timeout_q;
        err_parity_d  = err_parity_q;
        frame_cnt_d   = frame_cnt_q;
        wr_en         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rd_req) begin
                    state_d       = S_REQ;
                    err_timeout_d = 1'b0;
                    err_parity_d  = 1'b0;
                end
            end
            S_REQ: begin
                state_d = S_WAIT_START;
                cnt_d   = '0;
            end
            S_WAIT_START: begin
                cnt_d = cnt_q + CW'(1);
                if (sd) begin
                    state_d = S_SHIFT;
                    bit_d   = '0;
                    samp_d  = '0;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d       = S_ERR;
                    err_timeout_d = 1'b1;
                end
            end
            S_SHIFT: begin
                bit_d = bit_q + BW'(1);
`ifdef TSC_RX_PARITY_EN
                // Parity bit trails the data bits; the sample is already stored by then.
                if (bit_q == BW'(DW)) begin
                    if ((^sh_q) != sd)
                        err_parity_d = 1'b1;
                end else begin
                    sh_d = wr_data;
                end
`else
                sh_d = wr_data;
`endif
                if (bit_q == BW'(DW - 1))
                    wr_en = 1'b1;
                if (bit_q == BW'(LAST_BIT)) begin
                    bit_d  = '0;
                    samp_d = samp_q + AW'(1);
                    if (samp_q == AW'(NSAMP - 1)) begin
                        state_d = S_WAIT_CD;
                        cnt_d   = '0;
                    end
                end
            end
            S_WAIT_CD: begin
                cnt_d = cnt_q + CW'(1);
                // cd takes priority over a simultaneous timeout
                if (cd) begin
                    state_d     = S_DONE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    state_d       = S_ERR;
                    err_timeout_d = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        trig_time_d = trig_time_q;
        if (trd && !trd_q)
            trig_time_d = trigtm;
        rd_data_d = mem_q[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            samp_q        <= '0;
            sh_q          <= '0;
            err_timeout_q <= 1'b0;
            err_parity_q  <= 1'b0;
            frame_cnt_q   <= '0;
            trd_q         <= 1'b0;
            trig_time_q   <= '0;
            rd_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            samp_q        <= samp_d;
            sh_q          <= sh_d;
            err_timeout_q <= err_timeout_d;
            err_parity_q  <= err_parity_d;
            frame_cnt_q   <= frame_cnt_d;
            trd_q         <= trd;
            trig_time_q   <= trig_time_d;
            rd_data_q     <= rd_data_d;
        end
    end

    // Buffer contents are not reset; a partial frame simply leaves stale data behind.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[samp_q] <= wr_data;
    end

    assign sbf         = (state_q == S_REQ);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign err_timeout = err_timeout_q;
    assign frame_cnt   = frame_cnt_q;
    assign trig_time   = trig_time_q;
    assign rd_data     = rd_data_q;
`ifdef TSC_RX_PARITY_EN
    assign err_parity  = err_parity_q;
`else
    logic unused_parity;
    assign unused_parity = err_parity_q;
`endif

endmodule

// File: tb/tb_tsc_serial_rx.sv
// Directed bench for tsc_serial_rx: nominal frame, start/cd timeouts, cd tie, trigger latch,
// mid-frame reset, and (with TSC_RX_PARITY_EN) a corrupted parity bit.
module tb_tsc_serial_rx;

    localparam int NSAMP   = 32;
    localparam int DW      = 8;
    localparam int TIMEOUT = 1023;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req = 1'b0;
    logic        sbf;
    logic        sd = 1'b0;
    logic        cd = 1'b0;
    logic        trd = 1'b0;
    logic [31:0] trigtm = '0;
    logic [4:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [31:0] trig_time;
    logic        busy;
    logic        done;
    logic        err_timeout;
    logic [15:0] frame_cnt;
`ifdef TSC_RX_PARITY_EN
    logic        err_parity;
`endif

    int vectors = 0;
    int errors  = 0;

    tsc_serial_rx #(.NSAMP(NSAMP), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .sbf(sbf), .sd(sd), .cd(cd),
        .trd(trd), .trigtm(trigtm), .rd_addr(rd_addr), .rd_data(rd_data),
        .trig_time(trig_time), .busy(busy), .done(done), .err_timeout(err_timeout),
`ifdef TSC_RX_PARITY_EN
        .err_parity(err_parity),
`endif
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One active edge, then stop on the falling edge to drive and observe.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Request a frame and stream NSAMP samples of value base^k; optional side events mid-shift.
    task automatic apply_stimulus(input logic [7:0] base, input int flip_idx, input bit side);
        logic [7:0] v;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check_output("sbf_pulse", 32'(sbf), 32'd1);
        check_output("err_cleared", 32'(err_timeout), 32'd0);
        tick();
        check_output("sbf_low", 32'(sbf), 32'd0);
        tick();
        tick();
        sd = 1'b1;
        tick();
        for (int k = 0; k < NSAMP; k++) begin
            v = base ^ 8'(k);
            for (int b = DW - 1; b >= 0; b--) begin
                sd = v[b];
                if (side && k == 4 && b == 7) begin trd = 1'b1; trigtm = 32'h0000_1234; end
                if (side && k == 4 && b == 6) trigtm = 32'h0000_BEEF;
                if (side && k == 4 && b == 5) trd = 1'b0;
                if (side && k == 10 && b == 0) cd = 1'b1;
                if (side && k == 12 && b == 0) rd_req = 1'b1;
                tick();
                cd = 1'b0;
                rd_req = 1'b0;
                if (side && k == 4 && b == 7) check_output("trig_latch", trig_time, 32'h0000_1234);
                if (side && k == 4 && b == 5) check_output("trig_hold", trig_time, 32'h0000_1234);
                if (side && k == 10 && b == 0) check_output("cd_in_shift", {30'd0, busy, done}, 32'd2);
            end
`ifdef TSC_RX_PARITY_EN
            sd = (^v) ^ (k == flip_idx);
            tick();
`else
            if (flip_idx == k) $display("[TB] note: parity disabled, flip ignored");
`endif
        end
        sd = 1'b0;
    endtask

    initial begin
        #1;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_sbf", 32'(sbf), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_output("rst_trig_time", trig_time, 32'd0);
        check_output("rst_err", 32'(err_timeout), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Nominal frame: samples 0x00..0x1F, cd two clocks after the last bit
        apply_stimulus(8'h00, -1, 1'b1);
        check_output("wait_cd_busy", 32'(busy), 32'd1);
        tick();
        cd = 1'b1;
        tick();
        cd = 1'b0;
        check_output("done_pulse", 32'(done), 32'd1);
        check_output("frame_cnt_1", 32'(frame_cnt), 32'd1);
`ifdef TSC_RX_PARITY_EN
        check_output("parity_ok", 32'(err_parity), 32'd0);
`endif
        tick();
        check_output("done_once", 32'(done), 32'd0);
        check_output("idle_after_done", 32'(busy), 32'd0);
        rd_addr = 5'd7;
        tick();
        check_output("rd_data_7", 32'(rd_data), 32'h07);
        check_output("no_queued_req", 32'(busy), 32'd0);
        rd_addr = 5'd31;
        tick();
        check_output("rd_data_31", 32'(rd_data), 32'h1F);
        rd_addr = 5'd0;
        tick();
        check_output("rd_data_0", 32'(rd_data), 32'h00);

        // Start-bit timeout: sd held low
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check_output("to_sbf", 32'(sbf), 32'd1);
        for (int n = 0; n < TIMEOUT + 1; n++) tick();
        check_output("to_not_yet", {30'd0, busy, err_timeout}, 32'd2);
        tick();
        check_output("to_start_err", 32'(err_timeout), 32'd1);
        tick();
        check_output("to_start_idle", 32'(busy), 32'd0);
        check_output("to_start_err_sticky", 32'(err_timeout), 32'd1);

        // cd timeout: frame delivered, cd never arrives
        apply_stimulus(8'hA0, -1, 1'b0);
        for (int n = 0; n < TIMEOUT; n++) tick();
        check_output("cdto_not_yet", {30'd0, busy, err_timeout}, 32'd2);
        tick();
        check_output("cdto_err", 32'(err_timeout), 32'd1);
        check_output("cdto_frame_cnt", 32'(frame_cnt), 32'd1);
        tick();
        rd_addr = 5'd5;
        tick();
        check_output("cdto_rd_data_5", 32'(rd_data), 32'hA5);

        // cd arriving on the timeout cycle wins
        apply_stimulus(8'h5C, -1, 1'b0);
        for (int n = 0; n < TIMEOUT; n++) tick();
        cd = 1'b1;
        tick();
        cd = 1'b0;
        check_output("tie_done", 32'(done), 32'd1);
        check_output("tie_no_err", 32'(err_timeout), 32'd0);
        check_output("tie_frame_cnt", 32'(frame_cnt), 32'd2);
        tick();

`ifdef TSC_RX_PARITY_EN
        // Corrupt parity of sample 3: error flagged, frame still completes
        apply_stimulus(8'h30, 3, 1'b0);
        cd = 1'b1;
        tick();
        cd = 1'b0;
        check_output("par_done", 32'(done), 32'd1);
        check_output("par_err", 32'(err_parity), 32'd1);
        check_output("par_frame_cnt", 32'(frame_cnt), 32'd3);
        rd_addr = 5'd3;
        tick();
        check_output("par_rd_data_3", 32'(rd_data), 32'h33);
`endif

        // Reset mid-SHIFT
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        sd = 1'b1;
        tick();
        for (int n = 0; n < 5; n++) tick();
        check_output("mid_shift_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check_output("rst_mid_async", {29'd0, busy, sbf, done}, 32'd0);
        tick();
        check_output("rst_mid_edge", {29'd0, busy, sbf, done}, 32'd0);
        check_output("rst_mid_frame_cnt", 32'(frame_cnt), 32'd0);
        reset = 1'b0;
        sd = 1'b0;
        tick();
        check_output("rst_mid_idle", 32'(busy), 32'd0);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check_output("rst_mid_new_req", 32'(sbf), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
